regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Schedules the single register-file write port between the in-order pipeline writeback and one long-latency unit (LLU: divider or memory-miss path). Contains a busy-bit scoreboard that stalls issue on RAW/WAW hazards against pending LLU results. Includes a starvation guard so the LLU is never locked out. Sits between the decode/issue stage, the writeback stage and the register file write port.

Parameters:
STARVE_LIMIT, 4, consecutive cycles an LLU result may be denied before the pipeline is held.
MAX_OUTSTANDING, 2, maximum LLU operations in flight (1..31).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
issue_valid  in  1  instruction issuing this cycle
issue_is_llu  in  1  issuing instruction targets the LLU
issue_rd  in  5  destination register
issue_rs1  in  5  source 1
issue_rs2  in  5  source 2
issue_uses_rs1  in  1  rs1 is read
issue_uses_rs2  in  1  rs2 is read
issue_stall  out  1  combinational: issue must not proceed
pipe_wb_valid  in  1  pipeline writeback present (cannot be back-pressured)
pipe_wb_rd  in  5  pipeline destination
pipe_wb_data  in  32  pipeline result
pipe_hold  out  1  registered: pipeline must not present writeback this cycle
llu_valid  in  1  LLU result available
llu_rd  in  5  LLU destination
llu_data  in  32  LLU result
llu_ready  out  1  LLU result accepted this cycle
rf_write_enable  out  1  to register file
rf_rd_address  out  5  to register file
rf_rd_data  out  32  to register file

Behaviour:
- Reset (reset low, asynchronous): busy[31:0]=0, outstanding=0, starve_cnt=0, pipe_hold=0. Outputs while in reset: llu_ready=0, rf_write_enable=0.
- Pipeline writeback is effective only when pipe_wb_valid=1 and pipe_wb_rd!=0.
- Arbitration is combinational, fixed priority. pipe_hold=1: the LLU is granted, and the pipeline must have pipe_wb_valid=0 (contract; the bench asserts it). Otherwise an effective pipeline write wins. Otherwise the LLU is granted when llu_valid=1.
- llu_ready = llu_valid and granted. The LLU holds rd/data until llu_ready=1.
- rf_write_enable = 1 for an effective pipeline write, or for an LLU grant with llu_rd!=0. rf_rd_address and rf_rd_data are muxed from the winner; they are 0 when idle.
- An LLU result to x0 is accepted (llu_ready=1) but not written.
- Write latency to the register file: 0 cycles (same-cycle mux). The regfile captures at the next rising edge.
- Starvation guard:
  - starve_cnt increments each cycle llu_valid=1 and not granted; it resets to 0 on grant or when llu_valid=0.
  - When starve_cnt reaches STARVE_LIMIT-1 and the LLU is still denied, pipe_hold is set for exactly the next cycle.
  - pipe_hold clears the following cycle regardless.
- Scoreboard:
  - issue_stall = issue_valid AND any of:
    - uses_rs1 and busy[rs1]
    - uses_rs2 and busy[rs2]
    - busy[rd] (WAW)
    - issue_is_llu and outstanding==MAX_OUTSTANDING
  - busy[0] is never set.
  - On issue_valid & ~issue_stall & issue_is_llu: outstanding += 1, and busy[issue_rd] is set if rd!=0.
  - On llu_ready: outstanding -= 1 and busy[llu_rd] is cleared.
  - Simultaneous issue and LLU writeback: outstanding is unchanged, and set/clear apply to their own bits. If both target the same rd, the set wins (cannot occur because of the WAW stall, but is defined).
  - No bypass: a register cleared this cycle still reads busy until the next edge.
- Reset asserted mid-operation discards all busy state; the LLU is expected to be reset too.
- outstanding is $clog2(MAX_OUTSTANDING+1) bits wide and never over- or underflows. A completion while outstanding==0 is an assertion failure.

Decomposition:
- Shared package: REG_ADDR_W=5, XLEN=32, the rf_write_t struct {we, addr, data}, and an arbiter-grant enum {GNT_NONE, GNT_PIPE, GNT_LLU}.
- One natural sub-module, regfile_scoreboard: busy bits, outstanding counter and the issue_stall logic.
- The arbitration mux and the starvation counter stay in the top module.

Test Plan:
- Reset then idle → all outputs 0. Pipe write rd=5 data=0xDEADBEEF → rf_write_enable=1, rf_rd_address=5, same cycle.
- LLU issue rd=7, then issue of an instruction reading rs1=7 → issue_stall=1 until the cycle after llu_ready with llu_rd=7; then issue_stall=0.
- llu_valid with an effective pipe write every cycle, STARVE_LIMIT=4 → pipe_hold=1 on cycle 5, llu_ready=1 that cycle, pipe_hold=0 on cycle 6.
- Two LLU issues (MAX_OUTSTANDING=2), then a third LLU issue → issue_stall=1; after one llu_ready, the next-cycle issue succeeds.
- LLU result to x0 and pipe write to x0 in the same cycle → llu_ready=1, rf_write_enable=0, busy unchanged.
- Assert reset while busy[9]=1, outstanding=1 → after release, busy all 0, outstanding=0, and a read of rs1=9 does not stall.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and widths for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_write_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_LLU
  } grant_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for long-latency results: tracks pending LLU
// destinations and the in-flight count, and stalls hazardous issues.
module regfile_scoreboard
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_is_llu,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  issue_uses_rs1,
  input  logic                  issue_uses_rs2,
  input  logic                  llu_done,
  input  logic [REG_ADDR_W-1:0] llu_done_rd,
  output logic                  issue_stall
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

  logic [31:0]   busy;
  logic [31:0]   busy_next;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_next;
  logic          llu_issue;

  // Hazard detection; busy is the registered view, so a bit cleared this
  // cycle still stalls until the next edge.
  always_comb begin
    issue_stall = issue_valid &&
                  ((issue_uses_rs1 && busy[issue_rs1]) ||
                   (issue_uses_rs2 && busy[issue_rs2]) ||
                   busy[issue_rd] ||
                   (issue_is_llu && (outstanding == OUT_MAX)));
    llu_issue   = issue_valid && !issue_stall && issue_is_llu;
  end

  // Next busy/outstanding state; the set is applied after the clear so a
  // same-register collision leaves the bit set.
  always_comb begin
    busy_next = busy;
    if (llu_done) busy_next[llu_done_rd] = 1'b0;
    if (llu_issue) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;

    outstanding_next = outstanding;
    if (llu_issue && !llu_done) begin
      outstanding_next = outstanding + OW'(1);
    end else if (llu_done && !llu_issue && (outstanding != '0)) begin
      outstanding_next = outstanding - OW'(1);
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy        <= busy_next;
      outstanding <= outstanding_next;
    end
  end

  // A completion with nothing in flight means the LLU and scoreboard disagree.
  always_ff @(posedge clock) begin
    if (reset && llu_done) begin
      assert (outstanding != '0);
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between the in-order pipeline
// writeback and the long-latency unit, with a starvation guard that holds
// the pipeline for one cycle when the LLU has been denied too long.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_is_llu,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  issue_uses_rs1,
  input  logic                  issue_uses_rs2,
  output logic                  issue_stall,
  input  logic                  pipe_wb_valid,
  input  logic [REG_ADDR_W-1:0] pipe_wb_rd,
  input  logic [XLEN-1:0]       pipe_wb_data,
  output logic                  pipe_hold,
  input  logic                  llu_valid,
  input  logic [REG_ADDR_W-1:0] llu_rd,
  input  logic [XLEN-1:0]       llu_data,
  output logic                  llu_ready,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_rd_address,
  output logic [XLEN-1:0]       rf_rd_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

  grant_t        grant;
  rf_write_t     rf_wr;
  logic          pipe_eff;
  logic          llu_denied;
  logic [SW-1:0] starve_cnt;

  // Fixed-priority arbitration and write-port mux; nothing is granted
  // while reset is asserted.
  always_comb begin
    pipe_eff = pipe_wb_valid && (pipe_wb_rd != '0);
    grant    = GNT_NONE;
    if (!reset) begin
      grant = GNT_NONE;
    end else if (pipe_hold) begin
      grant = llu_valid ? GNT_LLU : GNT_NONE;
    end else if (pipe_eff) begin
      grant = GNT_PIPE;
    end else if (llu_valid) begin
      grant = GNT_LLU;
    end

    rf_wr = '0;
    case (grant)
      GNT_PIPE: begin
        rf_wr.we   = 1'b1;
        rf_wr.addr = pipe_wb_rd;
        rf_wr.data = pipe_wb_data;
      end
      GNT_LLU: begin
        // x0 results are accepted but never written.
        rf_wr.we   = (llu_rd != '0);
        rf_wr.addr = llu_rd;
        rf_wr.data = llu_data;
      end
      default: rf_wr = '0;
    endcase

    llu_ready  = (grant == GNT_LLU);
    llu_denied = llu_valid && (grant != GNT_LLU);
  end

  assign rf_write_enable = rf_wr.we;
  assign rf_rd_address   = rf_wr.addr;
  assign rf_rd_data      = rf_wr.data;

  // Starvation counter; the hold lasts one cycle because the LLU is always
  // granted while it is asserted, which clears the counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end else begin
      starve_cnt <= llu_denied ? starve_cnt + SW'(1) : '0;
      pipe_hold  <= llu_denied && (starve_cnt == STARVE_LAST);
    end
  end

  regfile_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_scoreboard (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_is_llu   (issue_is_llu),
    .issue_rd       (issue_rd),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_uses_rs1 (issue_uses_rs1),
    .issue_uses_rs2 (issue_uses_rs2),
    .llu_done       (llu_ready),
    .llu_done_rd    (llu_rd),
    .issue_stall    (issue_stall)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for the register-file writeback scheduler: directed scenarios plus
// a randomized run against a behavioural model of the scheduling rules.
module tb_regfile_wb_scheduler;

  localparam int STARVE_LIMIT = 4;
  localparam int MAX_OUT      = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid, issue_is_llu, issue_uses_rs1, issue_uses_rs2;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_hold;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_rd_address;
  logic [31:0] rf_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  regfile_wb_scheduler #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_llu(issue_is_llu),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_stall(issue_stall),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_hold(pipe_hold),
    .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
    .rf_write_enable(rf_write_enable), .rf_rd_address(rf_rd_address), .rf_rd_data(rf_rd_data)
  );

  // Pipeline must not present a writeback while held.
  always @(negedge clock) begin
    if (reset === 1'b1 && pipe_hold === 1'b1) begin
      n_cmp++;
      if (pipe_wb_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold_contract: pipe_wb_valid=%0b while pipe_hold, required 0", pipe_wb_valid);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_is_llu = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0;
    issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    pipe_wb_valid = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
    llu_valid = 0; llu_rd = 0; llu_data = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    step();
    step();
    reset = 1;
    step();
  endtask

  task automatic issue_llu(input logic [4:0] rd);
    issue_valid = 1; issue_is_llu = 1; issue_rd = rd;
    issue_uses_rs1 = 0; issue_uses_rs2 = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    llu_valid = 1; llu_rd = 3; llu_data = 32'h1234;
    pipe_wb_valid = 1; pipe_wb_rd = 4; pipe_wb_data = 32'h5678;
    #1;
    n_cmp++; if (llu_ready !== 1'b0) begin n_err++; $display("FAIL rst_llu_ready: got %0b want 0", llu_ready); end
    n_cmp++; if (rf_write_enable !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0b want 0", rf_write_enable); end
    n_cmp++; if (pipe_hold !== 1'b0) begin n_err++; $display("FAIL rst_hold: got %0b want 0", pipe_hold); end
    step();
    idle();
    reset = 1;
    step();
    issue_valid = 1; issue_rs1 = 6; issue_uses_rs1 = 1; issue_rd = 6;
    #1;
    n_cmp++; if (rf_write_enable !== 1'b0) begin n_err++; $display("FAIL idle_we: got %0b want 0", rf_write_enable); end
    n_cmp++; if (rf_rd_address !== 5'd0) begin n_err++; $display("FAIL idle_addr: got %0d want 0", rf_rd_address); end
    n_cmp++; if (rf_rd_data !== 32'd0) begin n_err++; $display("FAIL idle_data: got %0h want 0", rf_rd_data); end
    n_cmp++; if (llu_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %0b want 0", llu_ready); end
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %0b want 0", issue_stall); end
    step();
    idle();
  endtask

  task automatic test_pipe_write();
    do_reset();
    pipe_wb_valid = 1; pipe_wb_rd = 5; pipe_wb_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if (rf_write_enable !== 1'b1) begin n_err++; $display("FAIL pipe_we: got %0b want 1", rf_write_enable); end
    n_cmp++; if (rf_rd_address !== 5'd5) begin n_err++; $display("FAIL pipe_addr: got %0d want 5", rf_rd_address); end
    n_cmp++; if (rf_rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL pipe_data: got %0h want deadbeef", rf_rd_data); end
    step();
    idle();
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue_llu(5'd7);
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL raw_first_issue: got %0b want 0", issue_stall); end
    step();
    issue_is_llu = 0; issue_rd = 3; issue_rs1 = 7; issue_uses_rs1 = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL raw_wait%0d: got %0b want 1", i, issue_stall); end
      step();
    end
    llu_valid = 1; llu_rd = 7; llu_data = 32'h0000_0777;
    #1;
    n_cmp++; if (llu_ready !== 1'b1) begin n_err++; $display("FAIL raw_ready: got %0b want 1", llu_ready); end
    n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL raw_no_bypass: got %0b want 1", issue_stall); end
    step();
    llu_valid = 0;
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL raw_release: got %0b want 0", issue_stall); end
    step();
    idle();
  endtask

  task automatic test_starvation();
    do_reset();
    issue_llu(5'd10);
    step();
    idle();
    llu_valid = 1; llu_rd = 10; llu_data = 32'hCAFE0010;
    for (int c = 1; c <= 5; c++) begin
      pipe_wb_valid = (c != 5);
      pipe_wb_rd    = 5'(c);
      pipe_wb_data  = 32'h100 + 32'(c);
      #1;
      n_cmp++; if (pipe_hold !== (c == 5)) begin n_err++; $display("FAIL starve_hold c%0d: got %0b want %0b", c, pipe_hold, (c == 5)); end
      n_cmp++; if (llu_ready !== (c == 5)) begin n_err++; $display("FAIL starve_ready c%0d: got %0b want %0b", c, llu_ready, (c == 5)); end
      n_cmp++; if (rf_rd_address !== ((c == 5) ? 5'd10 : 5'(c))) begin n_err++; $display("FAIL starve_addr c%0d: got %0d want %0d", c, rf_rd_address, (c == 5) ? 10 : c); end
      step();
    end
    llu_valid = 0;
    pipe_wb_valid = 1; pipe_wb_rd = 6; pipe_wb_data = 32'h66;
    #1;
    n_cmp++; if (pipe_hold !== 1'b0) begin n_err++; $display("FAIL starve_hold_c6: got %0b want 0", pipe_hold); end
    n_cmp++; if (rf_rd_address !== 5'd6) begin n_err++; $display("FAIL starve_addr_c6: got %0d want 6", rf_rd_address); end
    step();
    idle();
  endtask

  task automatic test_max_outstanding();
    do_reset();
    issue_llu(5'd11);
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL max_issue1: got %0b want 0", issue_stall); end
    step();
    issue_llu(5'd12);
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL max_issue2: got %0b want 0", issue_stall); end
    step();
    issue_llu(5'd13);
    #1;
    n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL max_issue3: got %0b want 1", issue_stall); end
    step();
    llu_valid = 1; llu_rd = 11; llu_data = 32'hB0B;
    #1;
    n_cmp++; if (llu_ready !== 1'b1) begin n_err++; $display("FAIL max_ready: got %0b want 1", llu_ready); end
    n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL max_same_cycle: got %0b want 1", issue_stall); end
    step();
    llu_valid = 0;
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL max_after_ready: got %0b want 0", issue_stall); end
    step();
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    issue_llu(5'd0);
    step();
    idle();
    llu_valid = 1; llu_rd = 0; llu_data = 32'hABCD;
    pipe_wb_valid = 1; pipe_wb_rd = 0; pipe_wb_data = 32'h1111;
    #1;
    n_cmp++; if (llu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %0b want 1", llu_ready); end
    n_cmp++; if (rf_write_enable !== 1'b0) begin n_err++; $display("FAIL x0_we: got %0b want 0", rf_write_enable); end
    step();
    idle();
    issue_valid = 1; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_uses_rs1 = 1; issue_uses_rs2 = 1;
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL x0_busy: got %0b want 0", issue_stall); end
    step();
    issue_llu(5'd4);
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL x0_cnt1: got %0b want 0", issue_stall); end
    step();
    issue_llu(5'd5);
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL x0_cnt2: got %0b want 0", issue_stall); end
    step();
    issue_llu(5'd6);
    #1;
    n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL x0_cnt3: got %0b want 1", issue_stall); end
    step();
    idle();
  endtask

  task automatic test_reset_midop();
    do_reset();
    issue_llu(5'd9);
    step();
    idle();
    issue_valid = 1; issue_rd = 2; issue_rs1 = 9; issue_uses_rs1 = 1;
    #1;
    n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL mid_busy9: got %0b want 1", issue_stall); end
    #2;
    reset = 0;
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL mid_async_clear: got %0b want 0", issue_stall); end
    step();
    step();
    reset = 1;
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL mid_after_release: got %0b want 0", issue_stall); end
    step();
    issue_llu(5'd20);
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL mid_out1: got %0b want 0", issue_stall); end
    step();
    issue_llu(5'd21);
    #1;
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL mid_out2: got %0b want 0", issue_stall); end
    step();
    issue_llu(5'd22);
    #1;
    n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL mid_out3: got %0b want 1", issue_stall); end
    step();
    idle();
  endtask

  task automatic test_random();
    bit [31:0]   mbusy = '0;
    int          mout = 0;
    int          mstarve = 0;
    bit          mhold = 0;
    bit          presenting = 0;
    logic [31:0] cur_data = '0;
    int          pend_rd[$];
    bit          pipe_eff, llu_win, pipe_win, exp_we, exp_stall, fire, denied, new_hold;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!presenting && pend_rd.size() > 0 && $urandom_range(0, 2) != 0) begin
        presenting = 1;
        cur_data = $urandom;
      end
      llu_valid = presenting;
      llu_rd    = presenting ? 5'(pend_rd[0]) : 5'd0;
      llu_data  = presenting ? cur_data : 32'd0;
      pipe_wb_valid = !mhold && ($urandom_range(0, 3) != 0);
      pipe_wb_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_wb_data  = $urandom;
      issue_valid    = $urandom_range(0, 1);
      issue_is_llu   = ($urandom_range(0, 2) == 0);
      issue_rd       = 5'($urandom_range(0, 7));
      issue_rs1      = 5'($urandom_range(0, 7));
      issue_rs2      = 5'($urandom_range(0, 7));
      issue_uses_rs1 = $urandom_range(0, 1);
      issue_uses_rs2 = $urandom_range(0, 1);
      #1;
      pipe_eff  = pipe_wb_valid && (pipe_wb_rd != 0);
      llu_win   = llu_valid && (mhold || !pipe_eff);
      pipe_win  = !mhold && pipe_eff;
      exp_we    = pipe_win || (llu_win && llu_rd != 0);
      exp_addr  = pipe_win ? pipe_wb_rd : (llu_win ? llu_rd : 5'd0);
      exp_data  = pipe_win ? pipe_wb_data : (llu_win ? llu_data : 32'd0);
      exp_stall = issue_valid && ((issue_uses_rs1 && mbusy[issue_rs1]) ||
                                  (issue_uses_rs2 && mbusy[issue_rs2]) ||
                                  mbusy[issue_rd] ||
                                  (issue_is_llu && mout == MAX_OUT));
      n_cmp++; if (issue_stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall cyc%0d: got %0b want %0b", cyc, issue_stall, exp_stall); end
      n_cmp++; if (llu_ready !== llu_win) begin n_err++; $display("FAIL rnd_ready cyc%0d: got %0b want %0b", cyc, llu_ready, llu_win); end
      n_cmp++; if (rf_write_enable !== exp_we) begin n_err++; $display("FAIL rnd_we cyc%0d: got %0b want %0b", cyc, rf_write_enable, exp_we); end
      n_cmp++; if (pipe_hold !== mhold) begin n_err++; $display("FAIL rnd_hold cyc%0d: got %0b want %0b", cyc, pipe_hold, mhold); end
      if (!(llu_win && llu_rd == 0)) begin
        n_cmp++; if (rf_rd_address !== exp_addr) begin n_err++; $display("FAIL rnd_addr cyc%0d: got %0d want %0d", cyc, rf_rd_address, exp_addr); end
        n_cmp++; if (rf_rd_data !== exp_data) begin n_err++; $display("FAIL rnd_data cyc%0d: got %0h want %0h", cyc, rf_rd_data, exp_data); end
      end
      fire = issue_valid && !exp_stall && issue_is_llu;
      if (llu_win) begin
        mout--;
        mbusy[llu_rd] = 1'b0;
        void'(pend_rd.pop_front());
        presenting = 0;
      end
      if (fire) begin
        mout++;
        if (issue_rd != 0) mbusy[issue_rd] = 1'b1;
        pend_rd.push_back(int'(issue_rd));
      end
      denied   = llu_valid && !llu_win;
      new_hold = denied && (mstarve == STARVE_LIMIT - 1);
      mstarve  = denied ? mstarve + 1 : 0;
      mhold    = new_hold;
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_pipe_write();
    test_raw_stall();
    test_starvation();
    test_max_outstanding();
    test_x0();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
